// File: rtl/adc_peak_tracker.sv
// Windowed peak / peak-to-peak detector over a stream of ADC samples.
// It publishes max, min, Vpp and the range flags once per WIN_LEN samples, after discarding SETTLE_LEN settling samples.
module adc_peak_tracker #(
  parameter int DATA_W     = 12,
  parameter int WIN_LEN    = 1024,
  parameter int SETTLE_LEN = 16,
  parameter int HI_TH      = 3900,
  parameter int LO_TH      = 400
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clear,
  input  logic              adc_clk,
  input  logic [DATA_W-1:0] adc_data,
  output logic [DATA_W-1:0] peak_max,
  output logic [DATA_W-1:0] peak_min,
  output logic [DATA_W-1:0] vpp,
  output logic              over_range,
  output logic              under_range,
  output logic              result_valid,
  output logic              busy
);

  localparam int WCW = $clog2(WIN_LEN);
  localparam int SCW = (SETTLE_LEN > 0) ? $clog2(SETTLE_LEN + 1) : 1;
  localparam logic [WCW-1:0]    WIN_LAST    = WCW'(WIN_LEN - 1);
  localparam logic [SCW-1:0]    SETTLE_LAST = SCW'((SETTLE_LEN > 0) ? SETTLE_LEN - 1 : 0);
  localparam logic [DATA_W-1:0] HI_TH_W     = DATA_W'(HI_TH);
  localparam logic [DATA_W-1:0] LO_TH_W     = DATA_W'(LO_TH);
  localparam logic [DATA_W-1:0] ALL_ONES    = '1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_ACQ} state_e;
  localparam state_e START_ST = (SETTLE_LEN > 0) ? S_SETTLE : S_ACQ;

  state_e            state_q, state_d;
  logic              adc_clk_d_q, adc_clk_d_d;
  logic [DATA_W-1:0] samp_q, samp_d;
  logic              samp_vld_q, samp_vld_d;
  logic [SCW-1:0]    settle_cnt_q, settle_cnt_d;
  logic [WCW-1:0]    win_cnt_q, win_cnt_d;
  logic [DATA_W-1:0] run_max_q, run_max_d, run_min_q, run_min_d;
  logic [DATA_W-1:0] peak_max_q, peak_max_d, peak_min_q, peak_min_d, vpp_q, vpp_d;
  logic              over_q, over_d, under_q, under_d, rv_q, rv_d;

  logic              rise;
  logic [DATA_W-1:0] new_max, new_min, new_vpp;

  assign rise    = adc_clk & ~adc_clk_d_q;
  assign new_max = (samp_q > run_max_q) ? samp_q : run_max_q;
  assign new_min = (samp_q < run_min_q) ? samp_q : run_min_q;
  assign new_vpp = new_max - new_min;

  always_comb begin
    state_d      = state_q;
    adc_clk_d_d  = adc_clk;
    samp_d       = rise ? adc_data : samp_q;
    samp_vld_d   = rise;
    settle_cnt_d = settle_cnt_q;
    win_cnt_d    = win_cnt_q;
    run_max_d    = run_max_q;
    run_min_d    = run_min_q;
    peak_max_d   = peak_max_q;
    peak_min_d   = peak_min_q;
    vpp_d        = vpp_q;
    over_d       = over_q;
    under_d      = under_q;
    rv_d         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d      = START_ST;
          settle_cnt_d = '0;
          win_cnt_d    = '0;
          run_max_d    = '0;
          run_min_d    = ALL_ONES;
        end
      end
      S_SETTLE: begin
        if (samp_vld_q) begin
          if (settle_cnt_q == SETTLE_LAST) begin
            state_d      = S_ACQ;
            settle_cnt_d = '0;
          end else begin
            settle_cnt_d = settle_cnt_q + SCW'(1);
          end
        end
      end
      S_ACQ: begin
        if (samp_vld_q) begin
          if (win_cnt_q == WIN_LAST) begin
            // Last sample of the window: publish and restart without losing the next sample.
            peak_max_d = new_max;
            peak_min_d = new_min;
            vpp_d      = new_vpp;
            over_d     = (new_max >= HI_TH_W);
            under_d    = (new_vpp < LO_TH_W);
            rv_d       = 1'b1;
            win_cnt_d  = '0;
            run_max_d  = '0;
            run_min_d  = ALL_ONES;
          end else begin
            run_max_d = new_max;
            run_min_d = new_min;
            win_cnt_d = win_cnt_q + WCW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Disable or clear abandons the partial window; published results hold.
    if (!en || clear) begin
      state_d      = en ? START_ST : S_IDLE;
      settle_cnt_d = '0;
      win_cnt_d    = '0;
      run_max_d    = '0;
      run_min_d    = ALL_ONES;
      peak_max_d   = peak_max_q;
      peak_min_d   = peak_min_q;
      vpp_d        = vpp_q;
      over_d       = over_q;
      under_d      = under_q;
      rv_d         = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      adc_clk_d_q  <= 1'b0;
      samp_q       <= '0;
      samp_vld_q   <= 1'b0;
      settle_cnt_q <= '0;
      win_cnt_q    <= '0;
      run_max_q    <= '0;
      run_min_q    <= ALL_ONES;
      peak_max_q   <= '0;
      peak_min_q   <= '0;
      vpp_q        <= '0;
      over_q       <= 1'b0;
      under_q      <= 1'b0;
      rv_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      adc_clk_d_q  <= adc_clk_d_d;
      samp_q       <= samp_d;
      samp_vld_q   <= samp_vld_d;
      settle_cnt_q <= settle_cnt_d;
      win_cnt_q    <= win_cnt_d;
      run_max_q    <= run_max_d;
      run_min_q    <= run_min_d;
      peak_max_q   <= peak_max_d;
      peak_min_q   <= peak_min_d;
      vpp_q        <= vpp_d;
      over_q       <= over_d;
      under_q      <= under_d;
      rv_q         <= rv_d;
    end
  end

  assign peak_max     = peak_max_q;
  assign peak_min     = peak_min_q;
  assign vpp          = vpp_q;
  assign over_range   = over_q;
  assign under_range  = under_q;
  assign result_valid = rv_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_adc_peak_tracker.sv
// Directed bench for adc_peak_tracker: WIN_LEN=8, SETTLE_LEN=2, adc_clk = clk/4.
module tb_adc_peak_tracker;
  logic        clk = 1'b0;
  logic        rst_n, en, clear, adc_clk;
  logic [11:0] adc_data;
  logic [11:0] peak_max, peak_min, vpp;
  logic        over_range, under_range, result_valid, busy;

  int checks = 0;
  int errors = 0;

  adc_peak_tracker #(.DATA_W(12), .WIN_LEN(8), .SETTLE_LEN(2), .HI_TH(3900), .LO_TH(400)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .adc_clk(adc_clk), .adc_data(adc_data),
    .peak_max(peak_max), .peak_min(peak_min), .vpp(vpp), .over_range(over_range),
    .under_range(under_range), .result_valid(result_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // One adc_clk period (4 clk). pat = result_valid at {N0,N1,N2,N3}; clr pulses clear during the samp_vld cycle.
  task automatic send(input logic [11:0] val, input logic clr, output logic [3:0] pat);
    @(negedge clk); pat[3] = result_valid; adc_data = val; adc_clk = 1'b1;
    @(negedge clk); pat[2] = result_valid; clear = clr;
    @(negedge clk); pat[1] = result_valid; clear = 1'b0; adc_clk = 1'b0;
    @(negedge clk); pat[0] = result_valid;
  endtask

  task automatic window(input string tag, input logic [11:0] v [8]);
    logic [3:0] p;
    for (int i = 0; i < 8; i++) begin
      send(v[i], 1'b0, p);
      chk($sformatf("%s_rv%0d", tag, i), p, (i == 7) ? 4'b0010 : 4'b0000);
    end
  endtask

  task automatic settle2(input string tag);
    logic [3:0] p;
    for (int i = 0; i < 2; i++) begin
      send(12'd4000, 1'b0, p);
      chk($sformatf("%s_settle_rv%0d", tag, i), p, 4'b0000);
    end
  endtask

  task automatic results(input string tag, input int mx, input int mn, input int vp, input int ov, input int un);
    chk({tag, "_max"}, peak_max, mx);
    chk({tag, "_min"}, peak_min, mn);
    chk({tag, "_vpp"}, vpp, vp);
    chk({tag, "_over"}, over_range, ov);
    chk({tag, "_under"}, under_range, un);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    logic [11:0] w [8];
    logic [3:0]  p;
    rst_n = 1'b0; en = 1'b0; clear = 1'b0; adc_clk = 1'b0; adc_data = '0;
    repeat (3) @(negedge clk);
    results("reset", 0, 0, 0, 0, 0);
    chk("reset_rv", result_valid, 0);
    chk("reset_busy", busy, 0);

    // Window 1: mixed values
    rst_n = 1'b1; en = 1'b1;
    @(negedge clk);
    chk("w1_busy", busy, 1);
    send(12'd5, 1'b0, p); send(12'd6, 1'b0, p);
    w = '{100, 3000, 50, 2000, 800, 900, 1000, 1200};
    window("w1", w);
    results("w1", 3000, 50, 2950, 0, 0);

    // Window 2: constant, previous results held until the pulse
    w = '{default: 12'd2048};
    for (int i = 0; i < 7; i++) begin
      send(w[i], 1'b0, p);
      if (i == 6) begin
        chk("w2_hold_rv", p, 4'b0000);
        chk("w2_hold_max", peak_max, 3000);
      end
    end
    send(w[7], 1'b0, p);
    chk("w2_rv", p, 4'b0010);
    results("w2", 2048, 2048, 0, 0, 1);

    // Window 3: full-scale extremes
    w = '{4095, 0, 10, 20, 30, 40, 50, 60};
    window("w3", w);
    results("w3", 4095, 0, 4095, 1, 0);

    // Clear after 5 ACQ samples
    for (int i = 0; i < 5; i++) begin
      send(12'd3500, 1'b0, p);
      chk($sformatf("clr_part_rv%0d", i), p, 4'b0000);
    end
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    chk("clr_busy", busy, 1);
    chk("clr_hold_max", peak_max, 4095);
    settle2("clr");
    chk("clr_hold_vpp", vpp, 4095);
    w = '{1000, 1100, 1200, 1300, 1400, 1500, 1600, 1700};
    window("w4", w);
    results("w4", 1700, 1000, 700, 0, 0);

    // Clear coincident with the final sample's samp_vld
    for (int i = 0; i < 7; i++) send(12'd3000, 1'b0, p);
    send(12'd3000, 1'b1, p);
    chk("clr8_rv", p, 4'b0000);
    chk("clr8_busy", busy, 1);
    chk("clr8_hold_max", peak_max, 1700);
    settle2("clr8");
    w = '{200, 210, 220, 230, 240, 250, 260, 270};
    window("w5", w);
    results("w5", 270, 200, 70, 0, 1);

    // en dropped mid-window, then raised: settle repeats
    for (int i = 0; i < 3; i++) send(12'd10, 1'b0, p);
    en = 1'b0;
    @(negedge clk);
    chk("en_busy", busy, 0);
    chk("en_hold_max", peak_max, 270);
    en = 1'b1;
    @(negedge clk);
    chk("en_busy_back", busy, 1);
    settle2("en");
    w = '{2500, 2600, 2700, 2800, 2900, 3000, 3100, 3950};
    window("w6", w);
    results("w6", 3950, 2500, 1450, 1, 0);

    // Reset mid-ACQ
    for (int i = 0; i < 3; i++) send(12'd77, 1'b0, p);
    rst_n = 1'b0;
    @(negedge clk);
    results("rst2", 0, 0, 0, 0, 0);
    chk("rst2_busy", busy, 0);
    chk("rst2_rv", result_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
